// File: rtl/buttons_res.sv
// buttons_res
//   Latches elevator call requests. Three independent banks of set/clear
//   flags: in-car buttons (one per floor), hall "up" buttons (floors
//   0..top-1) and hall "down" buttons (floors 1..top). A button press sets
//   its flag, and the matching inactivate bit clears it. When both act on
//   the same edge, the clear takes priority. buttons_block masks every button
//   input but leaves clears working. Every output bit comes straight from its
//   flag register.
//
// Ports
//   clock                       system clock, rising-edge active
//   an_reset                    asynchronous active-low reset, clears all flags
//   buttons_block               1 = ignore new presses on all banks
//   btn_in[W-1:0]               in-car floor buttons
//   btn_up_out[W-2:0]           hall up buttons
//   btn_down_out[W-1:1]         hall down buttons
//   inactivate_in_levels        per-floor clear, in-car bank
//   inactivate_out_up_levels    per-floor clear, up bank
//   inactivate_out_down_levels  per-floor clear, down bank
//   active_in_levels            latched in-car requests
//   active_out_up_levels        latched up requests
//   active_out_down_levels      latched down requests
module buttons_res #(
  parameter int BUTTONS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     an_reset,
  input  logic                     buttons_block,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-2:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:1] btn_down_out,
  input  logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  input  logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
  output logic [BUTTONS_WIDTH-1:0] active_in_levels,
  output logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
  output logic [BUTTONS_WIDTH-1:1] active_out_down_levels
);

  localparam int W = BUTTONS_WIDTH;

  logic           press_en;
  logic [W-1:0]   in_q,   in_d;
  logic [W-2:0]   up_q,   up_d;
  logic [W-1:1]   down_q, down_d;

  assign press_en = ~buttons_block;

  // Per bit: the flag is set by an unmasked press or held from its previous
  // value, and then the clear is applied. Applying the clear last lets a
  // clear override a press that arrives on the same edge.
  always_comb begin
    in_d   = (in_q   | (btn_in       & {W{press_en}}))       & ~inactivate_in_levels;
    up_d   = (up_q   | (btn_up_out   & {(W-1){press_en}}))   & ~inactivate_out_up_levels;
    down_d = (down_q | (btn_down_out & {(W-1){press_en}}))   & ~inactivate_out_down_levels;
  end

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      in_q   <= '0;
      up_q   <= '0;
      down_q <= '0;
    end else begin
      in_q   <= in_d;
      up_q   <= up_d;
      down_q <= down_d;
    end
  end

  assign active_in_levels       = in_q;
  assign active_out_up_levels   = up_q;
  assign active_out_down_levels = down_q;

endmodule

// File: tb/tb_buttons_res.sv
// tb_buttons_res
//   Self-checking bench for buttons_res. A driver applies inputs on the
//   falling edge. It updates a per-floor request model and pushes the outputs
//   it expects after the next rising edge. A monitor pops one entry after
//   each rising edge and compares it with the DUT outputs.
module tb_buttons_res;

  localparam int BW = 8;
  localparam int EW = 3 * BW - 2;

  logic            clock;
  logic            an_reset;
  logic            buttons_block;
  logic [BW-1:0]   btn_in;
  logic [BW-2:0]   btn_up_out;
  logic [BW-1:1]   btn_down_out;
  logic [BW-1:0]   inactivate_in_levels;
  logic [BW-2:0]   inactivate_out_up_levels;
  logic [BW-1:1]   inactivate_out_down_levels;
  logic [BW-1:0]   active_in_levels;
  logic [BW-2:0]   active_out_up_levels;
  logic [BW-1:1]   active_out_down_levels;

  int tests_run = 0;
  int tests_failed = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model: one request bit per floor and per bank.
  bit m_in[BW];
  bit m_up[BW];
  bit m_dn[BW];

  buttons_res #(.BUTTONS_WIDTH(BW)) dut (
    .clock                      (clock),
    .an_reset                   (an_reset),
    .buttons_block              (buttons_block),
    .btn_in                     (btn_in),
    .btn_up_out                 (btn_up_out),
    .btn_down_out               (btn_down_out),
    .inactivate_in_levels       (inactivate_in_levels),
    .inactivate_out_up_levels   (inactivate_out_up_levels),
    .inactivate_out_down_levels (inactivate_out_down_levels),
    .active_in_levels           (active_in_levels),
    .active_out_up_levels       (active_out_up_levels),
    .active_out_down_levels     (active_out_down_levels)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic bit request_rule(input bit cur, input bit press, input bit clr, input bit blk);
    if (clr) return 1'b0;
    if (press && !blk) return 1'b1;
    return cur;
  endfunction

  function automatic logic [EW-1:0] model_packed();
    logic [BW-1:0] vi;
    logic [BW-2:0] vu;
    logic [BW-1:1] vd;
    vi = '0; vu = '0; vd = '0;
    for (int f = 0; f < BW; f++) begin
      vi[f] = m_in[f];
      if (f < BW - 1) vu[f] = m_up[f];
      if (f > 0)      vd[f] = m_dn[f];
    end
    return {vi, vu, vd};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic blk,
                      input logic [BW-1:0] bi, input logic [BW-2:0] bu, input logic [BW-1:1] bd,
                      input logic [BW-1:0] ii, input logic [BW-2:0] iu, input logic [BW-1:1] id);
    @(negedge clock);
    an_reset                   = rst;
    buttons_block              = blk;
    btn_in                     = bi;
    btn_up_out                 = bu;
    btn_down_out               = bd;
    inactivate_in_levels       = ii;
    inactivate_out_up_levels   = iu;
    inactivate_out_down_levels = id;
    for (int f = 0; f < BW; f++) begin
      if (!rst) begin
        m_in[f] = 0; m_up[f] = 0; m_dn[f] = 0;
      end else begin
        m_in[f] = request_rule(m_in[f], bi[f], ii[f], blk);
        if (f < BW - 1) m_up[f] = request_rule(m_up[f], bu[f], iu[f], blk);
        if (f > 0)      m_dn[f] = request_rule(m_dn[f], bd[f], id[f], blk);
      end
    end
    exp_q.push_back(model_packed());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("in_bank",   {active_in_levels, {(2*BW-2){1'b0}}},
                           {e[EW-1 -: BW], {(2*BW-2){1'b0}}});
        check("up_bank",   {{BW{1'b0}}, active_out_up_levels, {(BW-1){1'b0}}},
                           {{BW{1'b0}}, e[2*BW-3 -: BW-1], {(BW-1){1'b0}}});
        check("down_bank", {{(2*BW-1){1'b0}}, active_out_down_levels},
                           {{(2*BW-1){1'b0}}, e[BW-2:0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [BW-1:0] one_in;
    logic [BW-2:0] one_up;
    logic [BW-2:0] all_dn;

    an_reset = 1'b0;
    buttons_block = 1'b0;
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    inactivate_in_levels = '0; inactivate_out_up_levels = '0; inactivate_out_down_levels = '0;
    for (int f = 0; f < BW; f++) begin
      m_in[f] = 0; m_up[f] = 0; m_dn[f] = 0;
    end
    #1;
    check("reset_state", {active_in_levels, active_out_up_levels, active_out_down_levels}, '0);

    // Buttons held during reset are ignored; then the reset is released.
    step(1'b0, 1'b0, '1, '1, '1, '0, '0, '0);
    idle(2);

    // In-car buttons one at a time, 5 clocks each, accumulating to all ones.
    for (int k = 0; k < BW; k++) begin
      one_in = '0;
      one_in[k] = 1'b1;
      for (int c = 0; c < 5; c++) step(1'b1, 1'b0, one_in, '0, '0, '0, '0, '0);
    end
    idle(3);

    // Clear each in-car floor one pulse at a time.
    for (int k = 0; k < BW; k++) begin
      one_in = '0;
      one_in[k] = 1'b1;
      step(1'b1, 1'b0, '0, '0, '0, one_in, '0, '0);
      idle(1);
    end

    // Same-cycle press and clear on up[3]: the clear wins. The bit then sets
    // once the clear is released while the button is still held.
    one_up = '0;
    one_up[3] = 1'b1;
    step(1'b1, 1'b0, '0, one_up, '0, '0, one_up, '0);
    step(1'b1, 1'b0, '0, one_up, '0, '0, one_up, '0);
    step(1'b1, 1'b0, '0, one_up, '0, '0, '0, '0);
    idle(2);

    // Presses are masked while blocked and accepted once the block is cleared.
    all_dn = '1;
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, '0, '0, all_dn, '0, '0, '0);
    idle(1);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, '0, '0, all_dn, '0, '0, '0);
    idle(1);

    // A clear is honoured while blocked, and existing flags are held.
    step(1'b1, 1'b1, '1, '1, '0, '0, '0, 7'h05);
    idle(1);

    // Pressing in[0] again while it is already active.
    step(1'b1, 1'b0, 8'h01, '0, '0, '0, '0, '0);
    step(1'b1, 1'b0, 8'h01, '0, '0, '0, '0, '0);
    idle(1);
    step(1'b1, 1'b0, 8'h01, '0, '0, '0, '0, '0);
    idle(2);

    // Asynchronous reset between edges with all banks nonzero.
    step(1'b1, 1'b0, 8'hA5, 7'h33, 7'h4C, '0, '0, '0);
    idle(1);
    @(posedge clock);
    #3;
    an_reset = 1'b0;
    #1;
    check("async_reset", {active_in_levels, active_out_up_levels, active_out_down_levels}, '0);
    step(1'b0, 1'b0, '1, '1, '1, '0, '0, '0);
    idle(3);

    // Randomised traffic with sparse presses and clears, occasional block
    // and occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
           BW'($urandom & $urandom & $urandom),
           (BW-1)'($urandom & $urandom & $urandom),
           (BW-1)'($urandom & $urandom & $urandom),
           BW'($urandom & $urandom & $urandom & $urandom),
           (BW-1)'($urandom & $urandom & $urandom & $urandom),
           (BW-1)'($urandom & $urandom & $urandom & $urandom));
    end
    idle(2);

    // Every expected entry must have been consumed.
    @(posedge clock);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
